led_pattern_ctrl: RTL and testbench

- Pattern sequencer/controller for the 8-LED running-light datapath.
- Generates its own step timebase from clk_50m.
- Two debounced push-buttons select the pattern mode and step speed.
- Drives the registered led bus directly; sits between board keys and LED pins.

---
 rtl/led_pattern_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 8-LED running-light sequencer with debounced mode/speed keys and its own step timebase.
// Optional pause key and paused output are built in when LED_PATTERN_PAUSE_EN is defined.

module led_key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count only while the synchronized level disagrees with the accepted one; a bounce back restarts it.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;
endmodule

module led_pattern_ctrl #(
    parameter int BASE_DIV     = 12500000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_speed_n,
`ifdef LED_PATTERN_PAUSE_EN
    input  logic       key_pause_n,
    output logic       paused,
`endif
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       step
);
    typedef enum logic [1:0] {
        MODE_SHIFT_L  = 2'd0,
        MODE_SHIFT_R  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_e;

    localparam int PW = $clog2(BASE_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(BASE_DIV - 1);

    logic          mode_press;
    logic          speed_press;
    logic          run;
    logic          base_tick;
    logic          fire;
    logic [1:0]    step_last;

    mode_e         mode_q;
    mode_e         mode_d;
    logic [1:0]    speed_q;
    logic [1:0]    speed_d;
    logic [7:0]    led_q;
    logic [7:0]    led_d;
    logic          dir_q;
    logic          dir_d;
    logic          step_q;
    logic          step_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [1:0]    stcnt_q;
    logic [1:0]    stcnt_d;

    led_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .key_n_i (key_mode_n),
        .press_o (mode_press)
    );

    led_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_speed (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .key_n_i (key_speed_n),
        .press_o (speed_press)
    );

`ifdef LED_PATTERN_PAUSE_EN
    logic pause_press;
    logic paused_q;
    logic paused_d;

    led_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .key_n_i (key_pause_n),
        .press_o (pause_press)
    );

    assign paused_d = paused_q ^ pause_press;
    assign run      = ~paused_q;
    assign paused   = paused_q;
`else
    assign run = 1'b1;
`endif

    function automatic logic [7:0] seed_of(input mode_e m);
        case (m)
            MODE_SHIFT_L:  seed_of = 8'h01;
            MODE_SHIFT_R:  seed_of = 8'h80;
            MODE_PINGPONG: seed_of = 8'h01;
            default:       seed_of = 8'hFF;
        endcase
    endfunction

    // Step counter terminal value: N-1 base ticks per step for the current speed.
    always_comb begin
        case (speed_q)
            2'd0:    step_last = 2'd3;
            2'd1:    step_last = 2'd1;
            default: step_last = 2'd0;
        endcase
        base_tick = (pre_q == PRE_LAST);
        fire      = run && base_tick && (stcnt_q == step_last);
    end

    // Any key press clears the timebase so the new setting starts with a full period.
    always_comb begin
        pre_d   = pre_q;
        stcnt_d = stcnt_q;
        if (run) begin
            if (base_tick) begin
                pre_d   = '0;
                stcnt_d = fire ? 2'd0 : stcnt_q + 2'd1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
        if (mode_press || speed_press) begin
            pre_d   = '0;
            stcnt_d = 2'd0;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        led_d   = led_q;
        dir_d   = dir_q;
        step_d  = fire && !mode_press && !speed_press;
        if (speed_press) begin
            speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
        end
        if (mode_press) begin
            mode_d = mode_e'(mode_q + 2'd1);
            led_d  = seed_of(mode_e'(mode_q + 2'd1));
            dir_d  = 1'b0;
        end else if (step_d) begin
            case (mode_q)
                MODE_SHIFT_L: led_d = {led_q[6:0], led_q[7]};
                MODE_SHIFT_R: led_d = {led_q[0], led_q[7:1]};
                MODE_PINGPONG: begin
                    if (!dir_q) begin
                        if (led_q == 8'h80) begin
                            led_d = 8'h40;
                            dir_d = 1'b1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q == 8'h01) begin
                            led_d = 8'h02;
                            dir_d = 1'b0;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                default: led_d = ~led_q;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_SHIFT_L;
            speed_q  <= 2'd0;
            led_q    <= 8'h01;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            pre_q    <= '0;
            stcnt_q  <= 2'd0;
`ifdef LED_PATTERN_PAUSE_EN
            paused_q <= 1'b0;
`endif
        end else begin
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            pre_q    <= pre_d;
            stcnt_q  <= stcnt_d;
`ifdef LED_PATTERN_PAUSE_EN
            paused_q <= paused_d;
`endif
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign speed = speed_q;
    assign step  = step_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: a cycle-level reference model predicts every visible event,
// and a negedge monitor checks each DUT event (step pulse or output change) against the prediction.
`timescale 1ns/1ps

module tb_led_pattern_ctrl;
    localparam int BASE_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int PRESS_LAT    = DEBOUNCE_CYC + 3;

    typedef struct {
        int         cyc;
        logic [7:0] led;
        logic [1:0] mode;
        logic [1:0] speed;
        logic       step;
        logic       paused;
    } ev_t;

    logic       clk_50m     = 1'b0;
    logic       rst_n       = 1'b0;
    logic       key_mode_n  = 1'b1;
    logic       key_speed_n = 1'b1;
    logic [7:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       step;
    logic       dutPaused;

`ifdef LED_PATTERN_PAUSE_EN
    logic key_pause_n = 1'b1;
    logic paused;
    assign dutPaused = paused;
`else
    assign dutPaused = 1'b0;
`endif

    led_pattern_ctrl #(
        .BASE_DIV     (BASE_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .key_mode_n  (key_mode_n),
        .key_speed_n (key_speed_n),
`ifdef LED_PATTERN_PAUSE_EN
        .key_pause_n (key_pause_n),
        .paused      (paused),
`endif
        .led         (led),
        .mode        (mode),
        .speed       (speed),
        .step        (step)
    );

    always #10 clk_50m = ~clk_50m;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    ev_t  evQ[$];
    bit   modeAt[int];
    bit   speedAt[int];
    bit   pauseAt[int];

    // Reference model state: pattern position, speed level, cycles elapsed since last timebase clear.
    logic [7:0] mLed;
    int         mMode;
    int         mSpeed;
    int         mPos;
    int         mElapsed;
    bit         mDirRight;
    bit         mPaused;
    bit         mp, sp, pp, stepNow;
    ev_t        ev;

    function automatic int periodOf(input int s);
        return BASE_DIV * ((s == 0) ? 4 : (s == 1) ? 2 : 1);
    endfunction

    always @(posedge clk_50m) begin
        cyc++;
        if (!rst_n) begin
            mLed = 8'h01; mMode = 0; mSpeed = 0; mPos = 0;
            mElapsed = 0; mDirRight = 0; mPaused = 0;
        end else begin
            mp = modeAt.exists(cyc);
            sp = speedAt.exists(cyc);
            pp = pauseAt.exists(cyc);
            stepNow = 0;
            if (!mPaused) begin
                mElapsed++;
                if (mElapsed == periodOf(mSpeed)) begin
                    stepNow  = 1;
                    mElapsed = 0;
                end
            end
            if (mp || sp) begin
                stepNow  = 0;
                mElapsed = 0;
            end
            if (sp) mSpeed = (mSpeed + 1) % 3;
            if (mp) begin
                mMode = (mMode + 1) % 4;
                mDirRight = 0;
                mPos = 0;
                mLed = (mMode == 1) ? 8'h80 : (mMode == 3) ? 8'hFF : 8'h01;
            end else if (stepNow) begin
                case (mMode)
                    0: mLed = 8'((mLed << 1) | (mLed >> 7));
                    1: mLed = 8'((mLed >> 1) | (mLed << 7));
                    2: begin
                        if (!mDirRight) begin
                            if (mPos == 7) begin mPos = 6; mDirRight = 1; end
                            else mPos++;
                        end else begin
                            if (mPos == 0) begin mPos = 1; mDirRight = 0; end
                            else mPos--;
                        end
                        mLed = 8'(1 << mPos);
                    end
                    default: mLed = ~mLed;
                endcase
            end
            if (pp) mPaused = !mPaused;
            if (stepNow || mp || sp || pp) begin
                ev.cyc = cyc; ev.led = mLed; ev.mode = 2'(mMode); ev.speed = 2'(mSpeed);
                ev.step = stepNow; ev.paused = mPaused;
                evQ.push_back(ev);
            end
        end
    end

    // Monitor: any step pulse or output change is a DUT event and must match the oldest prediction.
    logic [7:0] pLed    = 8'h01;
    logic [1:0] pMode   = 2'd0;
    logic [1:0] pSpeed  = 2'd0;
    logic       pPaused = 1'b0;
    ev_t        expEv;

    always @(negedge clk_50m) begin
        if (rst_n) begin
            while (evQ.size() > 0 && evQ[0].cyc < cyc) begin
                expEv = evQ.pop_front();
                total++; bad++;
                $display("[TB] FAIL missing_event at cyc=%0d: got no event, required led=%h mode=%0d speed=%0d step=%0b",
                         expEv.cyc, expEv.led, expEv.mode, expEv.speed, expEv.step);
            end
            if (step || led != pLed || mode != pMode || speed != pSpeed || dutPaused != pPaused) begin
                total++;
                if (evQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_event cyc=%0d: got led=%h mode=%0d speed=%0d step=%0b paused=%0b, required no event",
                             cyc, led, mode, speed, step, dutPaused);
                end else begin
                    expEv = evQ.pop_front();
                    if (expEv.cyc != cyc || expEv.led != led || expEv.mode != mode || expEv.speed != speed ||
                        expEv.step != step || expEv.paused != dutPaused) begin
                        bad++;
                        $display("[TB] FAIL event: got cyc=%0d led=%h mode=%0d speed=%0d step=%0b paused=%0b, required cyc=%0d led=%h mode=%0d speed=%0d step=%0b paused=%0b",
                                 cyc, led, mode, speed, step, dutPaused,
                                 expEv.cyc, expEv.led, expEv.mode, expEv.speed, expEv.step, expEv.paused);
                    end
                end
            end
        end
        pLed = led; pMode = mode; pSpeed = speed; pPaused = dutPaused;
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, expv);
        end
    endtask

    task automatic checkResetState();
        checkOutput("reset_led", int'(led), 8'h01);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_speed", int'(speed), 0);
        checkOutput("reset_step", int'(step), 0);
        checkOutput("reset_paused", int'(dutPaused), 0);
    endtask

    // Hold the selected keys low for 'hold' cycles; a hold of DEBOUNCE_CYC or more is a real press.
    task automatic applyStimulus(input bit m, input bit s, input bit p, input int hold);
        int t0 = cyc;
        if (m) key_mode_n = 1'b0;
        if (s) key_speed_n = 1'b0;
`ifdef LED_PATTERN_PAUSE_EN
        if (p) key_pause_n = 1'b0;
`endif
        if (hold >= DEBOUNCE_CYC) begin
            if (m) modeAt[t0 + PRESS_LAT] = 1'b1;
            if (s) speedAt[t0 + PRESS_LAT] = 1'b1;
            if (p) pauseAt[t0 + PRESS_LAT] = 1'b1;
        end
        waitCycles(hold);
        key_mode_n  = 1'b1;
        key_speed_n = 1'b1;
`ifdef LED_PATTERN_PAUSE_EN
        key_pause_n = 1'b1;
`endif
        waitCycles(DEBOUNCE_CYC + 4);
    endtask

    // Issue a mode+speed press timed to land exactly on a cycle where a step would fire.
    task automatic pressAtStep();
        int r;
        bit found = 0;
        for (int i = 0; i < 64; i++) begin
            r = periodOf(mSpeed) - mElapsed;
            if (!mPaused && r <= PRESS_LAT && ((PRESS_LAT - r) % periodOf(mSpeed)) == 0) begin
                found = 1;
                break;
            end
            waitCycles(1);
        end
        checkOutput("coincident_press_alignment_found", int'(found), 1);
        if (found) applyStimulus(1'b1, 1'b1, 1'b0, DEBOUNCE_CYC + 2);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sel;
        waitCycles(3);
        checkResetState();
        rst_n = 1'b1;

        waitCycles(140);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        waitCycles(60);
        applyStimulus(1'b0, 1'b1, 1'b0, 12);
        waitCycles(30);
        applyStimulus(1'b0, 1'b1, 1'b0, 9);
        waitCycles(40);
        applyStimulus(1'b0, 1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b1, 1'b0, 8);

        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        waitCycles(70);

        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        waitCycles(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 5);
        waitCycles(20);

        pressAtStep();
        waitCycles(40);

`ifdef LED_PATTERN_PAUSE_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        waitCycles(100);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        waitCycles(50);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        waitCycles(40);
`endif

        for (int it = 0; it < 24; it++) begin
            waitCycles($urandom_range(0, 30));
            sel = $urandom_range(0, 9);
            if (sel <= 3)      applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(8, 20));
            else if (sel <= 6) applyStimulus(1'b0, 1'b1, 1'b0, $urandom_range(8, 20));
            else if (sel == 7) applyStimulus(1'b1, 1'b1, 1'b0, $urandom_range(8, 20));
            else if (sel == 8) applyStimulus($urandom_range(0, 1) == 1, 1'b1, 1'b0, $urandom_range(1, 7));
            else begin
`ifdef LED_PATTERN_PAUSE_EN
                applyStimulus(1'b0, 1'b0, 1'b1, $urandom_range(8, 20));
`else
                applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(8, 20));
`endif
            end
        end

        waitCycles(5);
        rst_n = 1'b0;
        #1;
        checkResetState();
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(60);

        checkOutput("queue_drained", evQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
